// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART debug command path: FSM states, error codes
// and frame constants.
package uart_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OP    = 3'd1,
        ST_AH    = 3'd2,
        ST_AL    = 3'd3,
        ST_DAT   = 3'd4,
        ST_CHK   = 3'd5,
        ST_ISSUE = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hAA;
    localparam int         FRAME_LEN     = 6;

    // States in which the inter-byte timeout counter runs.
    function automatic logic in_frame(input state_t s);
        return (s == ST_OP) || (s == ST_AH) || (s == ST_AL) ||
               (s == ST_DAT) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Command handshake between the frame sequencer (master) and the debug core (slave).
interface uart_cmd_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_addr,
        output cmd_wdata,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_addr,
        input  cmd_wdata,
        output cmd_ready
    );

endinterface

// File: rtl/toggle_event_detect.sv
// Turns each level change of a receiver toggle strobe into a one-cycle event.
// The first cycle after reset only captures the strobe level, so an unreset
// receiver cannot fake a byte.
module toggle_event_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic toggle,
    output logic ev
);

    logic r_armed;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_prev  <= toggle;
        end
    end

    assign ev = r_armed && (toggle ^ r_prev);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Assembles 6-byte SYNC/OP/ADDR_HI/ADDR_LO/DATA/CHK frames from a toggle-strobed
// byte stream and issues each valid frame as one command on a valid/ready port.
module uart_cmd_sequencer
    import uart_dbg_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 500000,
    parameter int         CNT_W          = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_toggle,
    uart_cmd_sequencer_if.master cmd,
    output logic                 err_pulse,
    output logic [1:0]           err_code,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_byte_ev;
    logic              w_timeout;
    logic              w_hs;
    logic              w_err;
    logic [1:0]        w_err_sel;
    logic              w_load_cmd;

    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_op;
    logic [7:0]        r_ah;
    logic [7:0]        r_al;
    logic [7:0]        r_dat;
    logic [7:0]        r_chk;

    logic              r_cmd_valid;
    logic [7:0]        r_cmd_op;
    logic [15:0]       r_cmd_addr;
    logic [7:0]        r_cmd_wdata;
    logic              r_err_pulse;
    logic [1:0]        r_err_code;

    toggle_event_detect u_ev (
        .clk    (clk),
        .rst_n  (rst_n),
        .toggle (rx_toggle),
        .ev     (w_byte_ev)
    );

    // Registered error fires on the edge where the counter would reach TIMEOUT_CYCLES.
    assign w_timeout = (r_cnt == TMO_LAST) && !w_byte_ev;
    assign w_hs      = r_cmd_valid && cmd.cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_err_sel   = ERR_NONE;
        w_load_cmd  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_byte_ev && (rx_data == SYNC_BYTE)) w_state_nxt = ST_OP;
            end
            ST_OP, ST_AH, ST_AL, ST_DAT: begin
                if (w_byte_ev) begin
                    case (r_state)
                        ST_OP:   w_state_nxt = ST_AH;
                        ST_AH:   w_state_nxt = ST_AL;
                        ST_AL:   w_state_nxt = ST_DAT;
                        default: w_state_nxt = ST_CHK;
                    endcase
                end else if (w_timeout) begin
                    w_err       = 1'b1;
                    w_err_sel   = ERR_TIMEOUT;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (w_byte_ev) begin
                    if (rx_data == r_chk) begin
                        w_load_cmd  = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_err       = 1'b1;
                        w_err_sel   = ERR_CHK;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_err       = 1'b1;
                    w_err_sel   = ERR_TIMEOUT;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_hs) w_state_nxt = ST_IDLE;
                // A byte arriving while a command is pending is dropped.
                if (w_byte_ev) begin
                    w_err     = 1'b1;
                    w_err_sel = ERR_OVERRUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_byte_ev || !in_frame(r_state)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= '0;
            r_ah  <= '0;
            r_al  <= '0;
            r_dat <= '0;
            r_chk <= '0;
        end else if (w_byte_ev) begin
            case (r_state)
                ST_IDLE: r_chk <= '0;
                ST_OP:   begin r_op  <= rx_data; r_chk <= r_chk ^ rx_data; end
                ST_AH:   begin r_ah  <= rx_data; r_chk <= r_chk ^ rx_data; end
                ST_AL:   begin r_al  <= rx_data; r_chk <= r_chk ^ rx_data; end
                ST_DAT:  begin r_dat <= rx_data; r_chk <= r_chk ^ rx_data; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= '0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else if (w_load_cmd) begin
            r_cmd_valid <= 1'b1;
            r_cmd_op    <= r_op;
            r_cmd_addr  <= {r_ah, r_al};
            r_cmd_wdata <= r_dat;
        end else if (w_hs) begin
            r_cmd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pulse <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_err_pulse <= w_err;
            if (w_err) r_err_code <= w_err_sel;
        end
    end

    assign cmd.cmd_valid = r_cmd_valid;
    assign cmd.cmd_op    = r_cmd_op;
    assign cmd.cmd_addr  = r_cmd_addr;
    assign cmd.cmd_wdata = r_cmd_wdata;
    assign err_pulse     = r_err_pulse;
    assign err_code      = r_err_code;
    assign busy          = (r_state != ST_IDLE);

endmodule
